// File: rtl/instr_fetch_unit.sv
// Fetch stage of the pipelined RV32I core: owns the PC, addresses the instruction
// memory and fills the IF/ID register, honouring stalls, redirects and fetch faults.
module instr_fetch_unit #(
    parameter int          DEPTH    = 256,
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int         AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [AW-1:0]    imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      pc,
    output logic             if_id_valid,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc_plus4,
    output logic             fetch_fault
);

    localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t      state;
    logic        in_range;
    logic [31:0] pc_plus4;

    assign imem_addr = pc[AW+1:2];
    assign pc_plus4  = pc + 32'd4;
    assign in_range  = ({2'b00, pc[31:2]} < 32'(DEPTH)) && (pc[1:0] == 2'b00);

    // PC, IF/ID register and fault/halt control.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            if_id_valid    <= 1'b0;
            if_id_instr    <= NOP;
            if_id_pc       <= 32'h0000_0000;
            if_id_pc_plus4 <= 32'h0000_0000;
            fetch_fault    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        // Redirect wins over stall; a misaligned target halts with pc kept.
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP;
                        if (redirect_pc[1:0] != 2'b00) begin
                            fetch_fault <= 1'b1;
                            state       <= HALT;
                        end else begin
                            pc <= redirect_pc;
                        end
                    end else if (stall) begin
                        pc <= pc;
                    end else if (!in_range) begin
                        fetch_fault <= 1'b1;
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP;
                        state       <= HALT;
                    end else begin
                        pc             <= pc_plus4;
                        if_id_valid    <= 1'b1;
                        if_id_instr    <= imem_rdata;
                        if_id_pc       <= pc;
                        if_id_pc_plus4 <= pc_plus4;
                    end
                end
                HALT: begin
                    if_id_valid <= 1'b0;
                    fetch_fault <= 1'b1;
                end
                default: begin
                    state       <= HALT;
                    if_id_valid <= 1'b0;
                    fetch_fault <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the pipelined RV32I core.
- Owns the program counter and drives the word address of the combinational instruction memory.
- Captures the returned instruction word into the IF/ID pipeline register.
- Handles decode-stage stalls, execute-stage redirects (branch/jump/jalr) and fetches that fall outside the memory.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words (AW = $clog2(DEPTH))
- WIDTH, 32, instruction word width
- RESET_PC, 32'h00000000, PC value after reset (word aligned)

Ports:
- clk  input  1  core clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- imem_addr  output  AW  word address to instruction memory; equals pc[AW+1:2]
- imem_rdata  input  WIDTH  instruction word from memory, combinational on imem_addr
- stall  input  1  hazard unit: hold PC and IF/ID
- redirect_valid  input  1  execute stage: taken branch or jump
- redirect_pc  input  32  redirect target byte address
- pc  output  32  current fetch PC
- if_id_valid  output  1  IF/ID holds a real instruction
- if_id_instr  output  WIDTH  IF/ID instruction
- if_id_pc  output  32  PC of if_id_instr
- if_id_pc_plus4  output  32  if_id_pc + 4, used for jal/jalr link
- fetch_fault  output  1  sticky fault flag: misaligned redirect or out-of-range fetch

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - pc = RESET_PC
  - if_id_valid = 0
  - if_id_instr = 32'h00000013 (NOP, addi x0,x0,0)
  - if_id_pc = 0 and if_id_pc_plus4 = 0
  - fetch_fault = 0
  - State is FETCH.
- imem_addr = pc[AW+1:2], purely combinational. Fetch latency is one cycle: the instruction at pc appears on if_id_instr after the next rising edge.
- A fetch is in range when pc[31:2] < DEPTH and pc[1:0] == 0.
- States are FETCH and HALT.
- FETCH, per rising edge, in priority order:
  1. redirect_valid = 1:
     - pc <= redirect_pc.
     - IF/ID is flushed: valid 0, instr NOP, pc fields hold their previous values.
     - Redirect overrides stall.
     - If redirect_pc[1:0] != 0: fetch_fault <= 1, pc is unchanged, go to HALT.
  2. stall = 1: pc and all IF/ID fields hold.
  3. Current fetch out of range:
     - fetch_fault <= 1, IF/ID flushed, pc held, go to HALT.
  4. Otherwise:
     - pc <= pc + 4 (32-bit wrap).
     - if_id_valid <= 1, if_id_instr <= imem_rdata, if_id_pc <= pc, if_id_pc_plus4 <= pc + 4.
- HALT:
  - pc frozen, if_id_valid = 0, fetch_fault = 1.
  - stall and redirect_valid are ignored.
  - Only reset exits HALT.
- A redirect to the instruction currently in IF/ID (self-loop, e.g. beq x2,x2,0) must refetch correctly each time, with one bubble per iteration.
- Reset asserted mid-stall or mid-redirect discards all in-flight state immediately.
- if_id_pc_plus4 is computed from the captured pc and never from the next pc.

Test Plan:
- Reset release, memory preloaded with 0x03200093 at word 0 and 0x03600113 at word 1, no stall/redirect: imem_addr 0, then 1. After edge 1: if_id_instr = 0x03200093, if_id_pc = 0, if_id_pc_plus4 = 4, pc = 4. After edge 2: if_id_instr = 0x03600113, if_id_pc = 4.
- stall held 3 cycles starting with pc = 8: pc stays 8, if_id_instr/if_id_pc unchanged, if_id_valid stays 1. On release, the next edge captures word 2 with if_id_pc = 8.
- redirect_valid with redirect_pc = 0x48 while pc = 0x20 and stall = 1: the next edge gives pc = 0x48 and if_id_valid = 0 with NOP. The following edge gives if_id_pc = 0x48 and the instruction at word 18.
- redirect_pc = 0x46: fetch_fault = 1, pc holds, state HALT. Further redirects and stalls have no effect. Asserting reset returns pc to 0 and clears fetch_fault.
- DEPTH = 4, free-running from 0: instructions at 0, 4, 8 and 0xC are captured. When pc = 0x10: fetch_fault = 1, if_id_valid = 0, pc stays 0x10.
- Reset asserted asynchronously between edges while pc = 0x14 and if_id_valid = 1: pc = RESET_PC and if_id_valid = 0 immediately, without waiting for a clock edge.
